// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: reset/exception addresses,
// forwarding select encodings and the IF/ID pipeline bundle.
package mips_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0180;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_W  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        valid;
        logic        adef;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and the rest of the pipeline
// (hazard unit, decode, imem, exception unit).
interface fetch_stage_if;
    logic        Stall_F;
    logic        Stall_D;
    logic [31:0] Instr_F;
    logic        PCSrc_D;
    logic [31:0] PCBranch_D;
    logic        Jump_D;
    logic [25:0] JumpAddr_D;
    logic        Jr_D;
    logic [1:0]  ForwardRs_D;
    logic [31:0] RD1_D;
    logic [31:0] ALUOut_M;
    logic [31:0] Result_W;
    logic        Exc_Req;
    logic [31:0] PC_F;
    logic [31:0] Instr_D;
    logic [31:0] PCPlus4_D;
    logic [31:0] PC_D;
    logic        Valid_D;
    logic        AdEF_D;

    // Pipeline/environment side: drives controls and imem data.
    modport master (
        output Stall_F, Stall_D, Instr_F, PCSrc_D, PCBranch_D, Jump_D,
               JumpAddr_D, Jr_D, ForwardRs_D, RD1_D, ALUOut_M, Result_W, Exc_Req,
        input  PC_F, Instr_D, PCPlus4_D, PC_D, Valid_D, AdEF_D
    );

    // Fetch stage side.
    modport slave (
        input  Stall_F, Stall_D, Instr_F, PCSrc_D, PCBranch_D, Jump_D,
               JumpAddr_D, Jr_D, ForwardRs_D, RD1_D, ALUOut_M, Result_W, Exc_Req,
        output PC_F, Instr_D, PCPlus4_D, PC_D, Valid_D, AdEF_D
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Generic IF/ID-style pipeline register: flush beats stall beats load,
// flush and reset both leave a bubble.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  mips_pkg::if_id_t d,
    output mips_pkg::if_id_t q
);
    import mips_pkg::*;

    localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pcplus4: 32'h0,
                                  valid: 1'b0, adef: 1'b0};

    if_id_t stage_d;
    if_id_t stage_q;

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = BUBBLE;
        end else if (!stall) begin
            stage_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS fetch stage: PC register, next-PC selection (exception, stall,
// decode redirects, sequential) and the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
    parameter logic [31:0] EXC_VECTOR = mips_pkg::EXC_VECTOR,
    parameter logic [31:0] NOP_INSTR  = mips_pkg::NOP_INSTR
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_stage_if.slave   bus
);
    import mips_pkg::*;

    logic [31:0] pc_d;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] jr_target;
    logic [31:0] jump_target;
    logic        redirect;
    logic        misaligned;
    if_id_t      fetch_bundle;
    if_id_t      ifid;

    always_comb begin
        jr_target = bus.RD1_D;
        case (bus.ForwardRs_D)
            FWD_W:   jr_target = bus.Result_W;
            FWD_M:   jr_target = bus.ALUOut_M;
            default: jr_target = bus.RD1_D;
        endcase
    end

    assign pc_plus4    = pc_q + 32'd4;
    assign jump_target = {ifid.pcplus4[31:28], bus.JumpAddr_D, 2'b00};

    // Decode operands are stale while D is stalled, so redirects wait for it.
    assign redirect = !bus.Stall_D && (bus.Jr_D || bus.Jump_D || bus.PCSrc_D);

    always_comb begin
        pc_d = pc_plus4;
        if (bus.Exc_Req) begin
            pc_d = EXC_VECTOR;
        end else if (bus.Stall_F) begin
            pc_d = pc_q;
        end else if (redirect) begin
            if (bus.Jr_D) begin
                pc_d = jr_target;
            end else if (bus.Jump_D) begin
                pc_d = jump_target;
            end else begin
                pc_d = bus.PCBranch_D;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign misaligned = (pc_q[1:0] != 2'b00);

    // A misaligned fetch carries a NOP so the bad word is never decoded.
    always_comb begin
        fetch_bundle.instr   = misaligned ? NOP_INSTR : bus.Instr_F;
        fetch_bundle.pc      = pc_q;
        fetch_bundle.pcplus4 = pc_plus4;
        fetch_bundle.valid   = 1'b1;
        fetch_bundle.adef    = misaligned;
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (bus.Stall_D),
        .flush (bus.Exc_Req || redirect),
        .d     (fetch_bundle),
        .q     (ifid)
    );

    assign bus.PC_F      = pc_q;
    assign bus.Instr_D   = ifid.instr;
    assign bus.PCPlus4_D = ifid.pcplus4;
    assign bus.PC_D      = ifid.pc;
    assign bus.Valid_D   = ifid.valid;
    assign bus.AdEF_D    = ifid.adef;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// control traffic checked against a cycle-level reference model.
module tb_fetch_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synthetic instruction memory: a distinct non-zero word per address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
    endfunction

    assign bus.Instr_F = imem(bus.PC_F);

    // Reference model of the architectural state seen at the outputs.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pcp4;
    logic        m_valid;
    logic        m_adef;

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pcd   = 32'h0;
        m_pcp4  = 32'h0;
        m_valid = 1'b0;
        m_adef  = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.Stall_F     = 1'b0;
        bus.Stall_D     = 1'b0;
        bus.PCSrc_D     = 1'b0;
        bus.PCBranch_D  = 32'h0;
        bus.Jump_D      = 1'b0;
        bus.JumpAddr_D  = 26'h0;
        bus.Jr_D        = 1'b0;
        bus.ForwardRs_D = 2'd0;
        bus.RD1_D       = 32'h0;
        bus.ALUOut_M    = 32'h0;
        bus.Result_W    = 32'h0;
        bus.Exc_Req     = 1'b0;
    endtask

    // Advance one clock; the model consumes the inputs applied before the edge.
    task automatic tick();
        logic [31:0] target;
        logic [31:0] next_pc;
        logic        taken;
        taken = !bus.Stall_D && (bus.Jr_D || bus.Jump_D || bus.PCSrc_D);
        if (bus.Jr_D)
            target = (bus.ForwardRs_D == 2'd1) ? bus.Result_W :
                     (bus.ForwardRs_D == 2'd2) ? bus.ALUOut_M : bus.RD1_D;
        else if (bus.Jump_D)
            target = {m_pcp4[31:28], bus.JumpAddr_D, 2'b00};
        else
            target = bus.PCBranch_D;
        if (bus.Exc_Req)      next_pc = 32'h180;
        else if (bus.Stall_F) next_pc = m_pc;
        else if (taken)       next_pc = target;
        else                  next_pc = m_pc + 32'd4;
        if (bus.Exc_Req || taken) begin
            m_instr = 32'h0; m_pcd = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0; m_adef = 1'b0;
        end else if (!bus.Stall_D) begin
            m_adef  = (m_pc % 4) != 0;
            m_instr = m_adef ? 32'h0 : imem(m_pc);
            m_pcd   = m_pc;
            m_pcp4  = m_pc + 32'd4;
            m_valid = 1'b1;
        end
        m_pc = next_pc;
        @(posedge clk);
        #1;
        $display("[%0t] PC_F=%h PC_D=%h PCPlus4_D=%h Instr_D=%h Valid_D=%0d AdEF_D=%0d",
                 $time, bus.PC_F, bus.PC_D, bus.PCPlus4_D, bus.Instr_D, bus.Valid_D, bus.AdEF_D);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.PC_F !== 32'h0 || bus.Instr_D !== 32'h0 || bus.PC_D !== 32'h0 ||
            bus.PCPlus4_D !== 32'h0 || bus.Valid_D !== 1'b0 || bus.AdEF_D !== 1'b0)
            $display("FAIL reset_state: PC_F=%h Instr_D=%h PC_D=%h PCPlus4_D=%h V=%0d A=%0d, need all zero",
                     bus.PC_F, bus.Instr_D, bus.PC_D, bus.PCPlus4_D, bus.Valid_D, bus.AdEF_D);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.PC_F !== 32'h4 || bus.Valid_D !== 1'b1 || bus.PC_D !== 32'h0 ||
            bus.PCPlus4_D !== 32'h4 || bus.Instr_D !== imem(32'h0))
            $display("FAIL first_fetch: PC_F=%h V=%0d PC_D=%h PCPlus4_D=%h Instr_D=%h, need 4/1/0/4/%h",
                     bus.PC_F, bus.Valid_D, bus.PC_D, bus.PCPlus4_D, bus.Instr_D, imem(32'h0));
        else n_pass++;
        tick();
        n_checks++;
        if (bus.PC_F !== 32'h8 || bus.Instr_D !== imem(32'h4) || bus.PC_D !== 32'h4)
            $display("FAIL second_fetch: PC_F=%h Instr_D=%h PC_D=%h, need 8/%h/4",
                     bus.PC_F, bus.Instr_D, bus.PC_D, imem(32'h4));
        else n_pass++;
    endtask

    task automatic test_stall();
        tick();
        tick();
        bus.Stall_F = 1'b1;
        bus.Stall_D = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (bus.PC_F !== 32'h10 || bus.PC_D !== 32'hC || bus.Instr_D !== imem(32'hC) || bus.Valid_D !== 1'b1)
                $display("FAIL stall_hold[%0d]: PC_F=%h PC_D=%h Instr_D=%h V=%0d, need 10/c/%h/1",
                         i, bus.PC_F, bus.PC_D, bus.Instr_D, bus.Valid_D, imem(32'hC));
            else n_pass++;
        end
        clear_inputs();
        tick();
        n_checks++;
        if (bus.PC_F !== 32'h14 || bus.PC_D !== 32'h10 || bus.Instr_D !== imem(32'h10))
            $display("FAIL stall_resume: PC_F=%h PC_D=%h Instr_D=%h, need 14/10/%h",
                     bus.PC_F, bus.PC_D, bus.Instr_D, imem(32'h10));
        else n_pass++;
    endtask

    task automatic test_branch();
        bus.PCSrc_D    = 1'b1;
        bus.PCBranch_D = 32'h40;
        tick();
        n_checks++;
        if (bus.PC_F !== 32'h40 || bus.Valid_D !== 1'b0 || bus.Instr_D !== 32'h0 || bus.PC_D !== 32'h0)
            $display("FAIL branch_redirect: PC_F=%h V=%0d Instr_D=%h PC_D=%h, need 40/0/0/0",
                     bus.PC_F, bus.Valid_D, bus.Instr_D, bus.PC_D);
        else n_pass++;
        clear_inputs();
        tick();
        n_checks++;
        if (bus.PC_D !== 32'h40 || bus.Instr_D !== imem(32'h40) || bus.Valid_D !== 1'b1 || bus.PC_F !== 32'h44)
            $display("FAIL branch_target_arrives: PC_D=%h Instr_D=%h V=%0d PC_F=%h, need 40/%h/1/44",
                     bus.PC_D, bus.Instr_D, bus.Valid_D, bus.PC_F, imem(32'h40));
        else n_pass++;
        bus.PCSrc_D    = 1'b1;
        bus.PCBranch_D = 32'h80;
        bus.Stall_D    = 1'b1;
        tick();
        n_checks++;
        if (bus.PC_F !== 32'h48 || bus.PC_D !== 32'h40 || bus.Valid_D !== 1'b1)
            $display("FAIL branch_under_stall_d: PC_F=%h PC_D=%h V=%0d, need 48/40/1",
                     bus.PC_F, bus.PC_D, bus.Valid_D);
        else n_pass++;
        clear_inputs();
        tick();
    endtask

    task automatic test_jr_forward();
        bus.Jr_D        = 1'b1;
        bus.ForwardRs_D = 2'd2;
        bus.ALUOut_M    = 32'h88;
        bus.RD1_D       = 32'h99;
        bus.Result_W    = 32'h70;
        tick();
        n_checks++;
        if (bus.PC_F !== 32'h88 || bus.Valid_D !== 1'b0)
            $display("FAIL jr_fwd_mem: PC_F=%h V=%0d, need 88/0", bus.PC_F, bus.Valid_D);
        else n_pass++;
        bus.ForwardRs_D = 2'd1;
        tick();
        n_checks++;
        if (bus.PC_F !== 32'h70)
            $display("FAIL jr_fwd_wb: PC_F=%h, need 70", bus.PC_F);
        else n_pass++;
        bus.ForwardRs_D = 2'd3;
        bus.Jump_D      = 1'b1;
        bus.JumpAddr_D  = 26'h0000_100;
        tick();
        n_checks++;
        if (bus.PC_F !== 32'h99)
            $display("FAIL jr_reserved_sel_and_priority: PC_F=%h, need 99", bus.PC_F);
        else n_pass++;
        clear_inputs();
        tick();
    endtask

    task automatic test_exception();
        bus.Exc_Req    = 1'b1;
        bus.Stall_F    = 1'b1;
        bus.Stall_D    = 1'b1;
        bus.Jump_D     = 1'b1;
        bus.JumpAddr_D = 26'h3ff_fff;
        tick();
        n_checks++;
        if (bus.PC_F !== 32'h180 || bus.Valid_D !== 1'b0 || bus.Instr_D !== 32'h0 ||
            bus.PC_D !== 32'h0 || bus.PCPlus4_D !== 32'h0)
            $display("FAIL exception_redirect: PC_F=%h V=%0d Instr_D=%h PC_D=%h PCPlus4_D=%h, need 180/0/0/0/0",
                     bus.PC_F, bus.Valid_D, bus.Instr_D, bus.PC_D, bus.PCPlus4_D);
        else n_pass++;
        clear_inputs();
        tick();
        n_checks++;
        if (bus.PC_D !== 32'h180 || bus.Instr_D !== imem(32'h180) || bus.PC_F !== 32'h184)
            $display("FAIL exception_handler_fetch: PC_D=%h Instr_D=%h PC_F=%h, need 180/%h/184",
                     bus.PC_D, bus.Instr_D, bus.PC_F, imem(32'h180));
        else n_pass++;
    endtask

    task automatic test_misaligned_wrap();
        bus.Jr_D  = 1'b1;
        bus.RD1_D = 32'h102;
        tick();
        n_checks++;
        if (bus.PC_F !== 32'h102)
            $display("FAIL misaligned_target: PC_F=%h, need 102", bus.PC_F);
        else n_pass++;
        clear_inputs();
        tick();
        n_checks++;
        if (bus.AdEF_D !== 1'b1 || bus.Instr_D !== 32'h0 || bus.PC_D !== 32'h102 || bus.Valid_D !== 1'b1)
            $display("FAIL adef_flag: AdEF_D=%0d Instr_D=%h PC_D=%h V=%0d, need 1/0/102/1",
                     bus.AdEF_D, bus.Instr_D, bus.PC_D, bus.Valid_D);
        else n_pass++;
        bus.PCSrc_D    = 1'b1;
        bus.PCBranch_D = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (bus.PC_F !== 32'h0 || bus.PC_D !== 32'hFFFF_FFFC || bus.PCPlus4_D !== 32'h0 || bus.AdEF_D !== 1'b0)
            $display("FAIL pc_wrap: PC_F=%h PC_D=%h PCPlus4_D=%h AdEF_D=%0d, need 0/fffffffc/0/0",
                     bus.PC_F, bus.PC_D, bus.PCPlus4_D, bus.AdEF_D);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.PCSrc_D    = 1'b1;
        bus.PCBranch_D = 32'h200;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.PC_F !== 32'h0 || bus.Valid_D !== 1'b0 || bus.PC_D !== 32'h0)
            $display("FAIL async_reset: PC_F=%h V=%0d PC_D=%h, need 0/0/0", bus.PC_F, bus.Valid_D, bus.PC_D);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_inputs();
        model_reset();
        tick();
        n_checks++;
        if (bus.PC_F !== 32'h4 || bus.PC_D !== 32'h0 || bus.Valid_D !== 1'b1)
            $display("FAIL reset_no_pending_redirect: PC_F=%h PC_D=%h V=%0d, need 4/0/1",
                     bus.PC_F, bus.PC_D, bus.Valid_D);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            clear_inputs();
            bus.Stall_D     = ($urandom_range(0, 9) < 2);
            bus.Stall_F     = bus.Stall_D ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 19) == 0);
            bus.Jr_D        = ($urandom_range(0, 9) == 0);
            bus.Jump_D      = ($urandom_range(0, 9) == 0);
            bus.PCSrc_D     = ($urandom_range(0, 9) == 0);
            bus.Exc_Req     = ($urandom_range(0, 29) == 0);
            bus.ForwardRs_D = 2'($urandom_range(0, 3));
            bus.JumpAddr_D  = 26'($urandom);
            bus.PCBranch_D  = $urandom & 32'hFFFF_FFFC;
            bus.RD1_D       = $urandom & (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            bus.ALUOut_M    = $urandom & 32'hFFFF_FFFC;
            bus.Result_W    = $urandom;
            tick();
            n_checks++;
            if (bus.PC_F !== m_pc || bus.Instr_D !== m_instr || bus.PC_D !== m_pcd ||
                bus.PCPlus4_D !== m_pcp4 || bus.Valid_D !== m_valid || bus.AdEF_D !== m_adef)
                $display("FAIL random[%0d]: got PC_F=%h I=%h PC_D=%h P4=%h V=%0d A=%0d need %h %h %h %h %0d %0d",
                         i, bus.PC_F, bus.Instr_D, bus.PC_D, bus.PCPlus4_D, bus.Valid_D, bus.AdEF_D,
                         m_pc, m_instr, m_pcd, m_pcp4, m_valid, m_adef);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_stall();
        test_branch();
        test_jr_forward();
        test_exception();
        test_misaligned_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection, and the IF/ID pipeline register.
- Consumes the hazard unit's Stall_F, Stall_D and ForwardRs_D. Uses ForwardRs_D to resolve the jr target in Decode.
- Produces the Decode-stage instruction/PC bundle, which feeds the hazard unit's Rs_D/Rt_D extraction.
- Handles the exception redirect to the vector and flags instruction-address-misaligned (AdEF) fetches.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset
EXC_VECTOR  32'h0000_0180  exception handler entry address
NOP_INSTR  32'h0000_0000  instruction injected on flush/bubble (sll $0,$0,0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
Stall_F  in  1  hold PC register (from hazard unit)
Stall_D  in  1  hold IF/ID register (from hazard unit)
Instr_F  in  32  instruction read combinationally from imem at PC_F
PCSrc_D  in  1  branch taken, resolved in Decode
PCBranch_D  in  32  branch target
Jump_D  in  1  j/jal in Decode
JumpAddr_D  in  26  instr_index field
Jr_D  in  1  jr/jalr in Decode
ForwardRs_D  in  2  jr source select: 0 regfile, 1 Result_W, 2 ALUOut_M
RD1_D  in  32  regfile Rs read data
ALUOut_M  in  32  Memory-stage ALU result
Result_W  in  32  Writeback result
Exc_Req  in  1  exception taken (from exception unit, Memory stage)
PC_F  out  32  fetch address to imem
Instr_D  out  32  IF/ID instruction
PCPlus4_D  out  32  IF/ID PC+4
PC_D  out  32  IF/ID PC (for EPC capture)
Valid_D  out  1  IF/ID holds a real instruction
AdEF_D  out  1  fetch address misaligned for the instruction in D

Behaviour:
- Reset (async, rst_n=0):
  - PC_F=RESET_PC.
  - Instr_D=NOP_INSTR, PCPlus4_D=0, PC_D=0, Valid_D=0, AdEF_D=0.
- First rising edge after release:
  - IF/ID loads the RESET_PC fetch with Valid_D=1.
  - PC_F becomes RESET_PC+4.
- Jr target mux:
  - ForwardRs_D=0 selects RD1_D; 1 selects Result_W; 2 selects ALUOut_M; 3 is reserved and selects RD1_D.
- Next-PC priority, highest first:
  1. Exc_Req → EXC_VECTOR. Ignores Stall_F.
  2. Stall_F=1 → hold PC_F.
  3. Decode redirects apply only when Stall_D=0, since redirects computed under a stall use stale operands:
     - Jr_D → jr target.
     - Jump_D → {PCPlus4_D[31:28], JumpAddr_D, 2'b00}.
     - PCSrc_D → PCBranch_D.
  4. Otherwise PC_F+4, 32-bit wrap (32'hFFFF_FFFC → 0).
- Delay slots are not implemented: a redirect squashes the fetched instruction.
- IF/ID update on each edge, priority highest first:
  1. Exc_Req → bubble: NOP_INSTR, Valid_D=0, AdEF_D=0. PC_D/PCPlus4_D are cleared to 0. Overrides Stall_D.
  2. Stall_D=1 → hold all fields.
  3. Redirect taken (Jr_D|Jump_D|PCSrc_D with Stall_D=0) → bubble as above.
  4. Otherwise load Instr_F, PC_F, PC_F+4 and Valid_D=1.
     - AdEF_D = (PC_F[1:0]≠0).
     - When AdEF_D=1, Instr_D=NOP_INSTR, so the bad word is never decoded.
- Simultaneous Jr_D and Jump_D (illegal decode): Jr_D wins.
- Stall_F=1 with Stall_D=0 is not generated by the hazard unit. If it occurs, IF/ID loads and the PC holds, which duplicates the fetch. No protection is required.
- Reset mid-operation: all state returns to reset values immediately; no pending redirect survives.
- Latency:
  - The redirect target appears on PC_F one cycle after the redirect cycle.
  - The first target instruction reaches Instr_D two cycles after the redirect cycle.

Decomposition:
- Shared package mips_pkg holds:
  - RESET_PC, EXC_VECTOR, NOP_INSTR.
  - ForwardRs_D encodings: FWD_RF=0, FWD_W=1, FWD_M=2.
  - An if_id_t struct {instr, pc, pcplus4, valid, adef}.
- One sub-module is natural: if_id_reg, the pipeline register with stall/flush/async-reset, reusable for later stages.
- PC register and next-PC logic stay in fetch_stage.

Test Plan:
1. Reset release → PC_F=0, then 4, 8; Instr_D follows the imem words at 0 and 4; Valid_D rises one cycle after release.
2. Stall_F=Stall_D=1 for 2 cycles at PC_F=0x10 → PC_F stays 0x10 and IF/ID is frozen; sequencing resumes at 0x14.
3. PCSrc_D=1, PCBranch_D=0x40, Stall_D=0 → next PC_F=0x40, Instr_D is a bubble (Valid_D=0), then the word at 0x40 arrives. Repeat with Stall_D=1 → no redirect.
4. Jr_D=1, ForwardRs_D=2, ALUOut_M=0x88, RD1_D=0x99 → PC_F=0x88. Repeat with ForwardRs_D=1, Result_W=0x70 → PC_F=0x70.
5. Exc_Req=1 coinciding with Stall_F=Stall_D=1 and Jump_D=1 → PC_F=0x180, IF/ID bubble.
6. Jr target 0x102 → PC_F=0x102; next cycle AdEF_D=1, Instr_D=NOP, PC_D=0x102. Also PC_F=0xFFFF_FFFC → next PC_F=0x0.
